vx_wrr_arbiter: RTL and testbench
=================================

# VX_wrr_arbiter

Weighted round-robin arbiter with optional grant locking. It is the next-generation member of the arbiter family, used where requesters need unequal bandwidth shares, such as memory-side ports and shared-bus muxes. Each requester gets up to `weight[i]` accepted grants per epoch, and a requester can hold the grant for multi-beat transfers. The grant path is combinational, state advances on accepted grants, and it drops into the same request/grant/ready handshake as the existing arbiters.

## Interface
- `NUM_REQS`, 4: number of requesters, ≥1.
- `WEIGHT_WIDTH`, 4: bits per weight.
- `LOCK_ENABLE`, 1: 1 enables `requests_lock`; 0 ignores it.
- `LOG_NUM_REQS`, `LOG2UP(NUM_REQS)`: index width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `requests`  in  NUM_REQS  request vector.
- `weights`  in  NUM_REQS*WEIGHT_WIDTH  per-requester weight; requester i is at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- `requests_lock`  in  NUM_REQS  hold the grant after this beat.
- `grant_index`  out  LOG_NUM_REQS  winner index.
- `grant_onehot`  out  NUM_REQS  winner one-hot.
- `grant_valid`  out  1  `|requests`.
- `grant_ready`  in  1  consumer accepts the grant this cycle.

## Operation
- Effective weight: w'[i] = (weights[i]==0) ? 1 : weights[i]. No requester starves.
- State:
  - `ptr[LOG_NUM_REQS]`: round-robin start point.
  - `credit[i][WEIGHT_WIDTH]`: remaining grants per requester.
  - `locked`, `lock_idx`: lock state.
- Refill condition: `refill = ~|(requests & credit_nz)`, where credit_nz[i] = (credit[i]!=0).
- Eligible set: `eligible = refill ? requests : (requests & credit_nz)`.
- Winner selection:
  - If `locked && requests[lock_idx]`, the winner is `lock_idx`, regardless of credit.
  - Otherwise the winner is the first eligible index scanning ptr, ptr+1, … with wrap modulo NUM_REQS.
- On accept (`grant_valid && grant_ready`), all updates happen at the posedge:
  - Credit: if `refill`, credit[j] = w'[j] for all j, then the winner's credit is decremented. Otherwise only the winner's credit is decremented, saturating at 0.
  - Pointer: ptr = winner while the winner's post-update credit is ≠0 and it is not locked. Otherwise ptr = winner+1, wrapping at NUM_REQS (not at 2^LOG_NUM_REQS).
  - Lock: `locked` = LOCK_ENABLE && requests_lock[winner]; `lock_idx` = winner.
- No accept: all state holds.
- Lock release: `locked` clears in the same cycle the locked requester deasserts `requests` (the next winner follows normal RR). `locked` is also cleared by an accepted beat with the lock bit low.
- Weight changes take effect only at the next refill.
- NUM_REQS==1: grant_index=0, grant_onehot=requests, and the credit/ptr logic is optimised away.

## Timing
- Zero-cycle path from requests to grant (combinational). State updates one cycle after accept.
- The grant is not sticky when `grant_ready`=0, unless locked: the grant follows `requests`. It is stable only if `requests` is stable.
- Reset values:
  - ptr=0, every credit=0, locked=0.
  - With requests=0 after reset: grant_valid=0, grant_index=0, grant_onehot=0.
  - The first accepted grant after reset is always a refill.
- Reset asserted mid-lock: the lock is dropped immediately (async). Arbitration resumes from index 0.
- When every pending requester is at credit 0, the refill and the grant happen in the same cycle. There are no idle bubbles.

## Structure
- Add `ARB_TYPE_WEIGHTED = 4` alongside the existing arbiter type constants in the shared GPU package, so the generic arbiter wrapper can select this block. Weights remain a flat port, with no packed-struct typedef.
- One sub-module: `VX_priority_arbiter`, applied to `eligible` rotated right by `ptr`. Its index is rotated back with modulo-NUM_REQS addition.
- Everything else stays in a single module: credit array, pointer, lock FSM (UNLOCKED→LOCKED on an accepted beat with the lock bit set; LOCKED→UNLOCKED on release).

## Test plan
- **Weights.** NUM_REQS=4, weights={1,2,3,0} (req0..3), requests=4'b1111, ready=1 constantly. Required grant sequence per epoch: 0,1,1,2,2,2,3, repeating for 3 epochs.
- **Backpressure.** Same config with ready toggling 1,0,1,0. Grants advance only on ready cycles. The index sequence matches the case above, and credit/ptr are unchanged on ready=0 cycles.
- **Lock.** requests=4'b0011, requests_lock[1]=1 for 5 beats. Required: after req1 wins, 5 consecutive grants go to 1 even though its credit is exhausted. Then lock_bit=0 gives one more grant to 1, after which grants return to RR order.
- **Lock release by drop.** Req1 drops its request while locked. In that same cycle the grant moves to req0.
- **Refill.** Only req2 requests, weight=1, for 4 cycles. Required: grant to 2 every cycle with no bubbles (a refill each cycle), and grant_valid stays high.
- **Reset and wrap.** Assert reset_n=0 mid-lock: outputs with requests=0 read valid=0, index=0, onehot=0. Also cover NUM_REQS=3, where the wrap from ptr=2 goes to 0 and never to 3.

Source files
------------

// File: rtl/vx_wrr_arbiter_pkg.sv
// Shared arbiter definitions: arbiter type selectors, lock FSM encoding
// and an index-width helper used by the weighted round-robin arbiter.
package vx_wrr_arbiter_pkg;

    localparam int ARB_TYPE_ROUND_ROBIN = 0;
    localparam int ARB_TYPE_PRIORITY    = 1;
    localparam int ARB_TYPE_MATRIX      = 2;
    localparam int ARB_TYPE_CYCLIC      = 3;
    localparam int ARB_TYPE_WEIGHTED    = 4;

    localparam logic [0:0] LOCK_ST_UNLOCKED = 1'b0;
    localparam logic [0:0] LOCK_ST_LOCKED   = 1'b1;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_wrr_arbiter_priority.sv
// Fixed-priority picker: lowest set request index wins.
module VX_priority_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int LOG_NUM_REQS = 2
) (
    input  logic [NUM_REQS-1:0]     requests,
    output logic [LOG_NUM_REQS-1:0] grant_index
);

    // Scan upward and keep the first set bit.
    always_comb begin
        logic found;
        found       = 1'b0;
        grant_index = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (requests[i] && !found) begin
                grant_index = LOG_NUM_REQS'(i);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_wrr_arbiter.sv
// Weighted round-robin arbiter with optional grant locking. Combinational
// grant; credits, pointer and lock state advance only on accepted grants.
module vx_wrr_arbiter
    import vx_wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int LOCK_ENABLE  = 1,
    parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQS-1:0]              requests,
    input  logic [NUM_REQS*WEIGHT_WIDTH-1:0] weights,
    input  logic [NUM_REQS-1:0]              requests_lock,
    output logic [LOG_NUM_REQS-1:0]          grant_index,
    output logic [NUM_REQS-1:0]              grant_onehot,
    output logic                             grant_valid,
    input  logic                             grant_ready
);

    if (NUM_REQS == 1) begin : g_single
        logic unused_single;
        assign unused_single = ^{clk, reset_n, weights, requests_lock, grant_ready};
        assign grant_index   = '0;
        assign grant_onehot  = requests;
        assign grant_valid   = requests[0];
    end else begin : g_wrr
        logic [LOG_NUM_REQS-1:0]                   ptr_q, ptr_d;
        logic [NUM_REQS-1:0][WEIGHT_WIDTH-1:0]     credit_q, credit_d;
        logic [0:0]                                lock_st_q, lock_st_d;
        logic [LOG_NUM_REQS-1:0]                   lock_idx_q, lock_idx_d;
        logic [NUM_REQS-1:0]                       credit_nz, eligible, eligible_rot;
        logic                                      refill, lock_hit, accept;
        logic [LOG_NUM_REQS-1:0]                   rot_idx, rr_winner, winner;

        // Eligible set, then rotate it right by ptr so index 0 is the RR start.
        always_comb begin
            int unsigned src;
            src = 0;
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                credit_nz[i] = (credit_q[i] != '0);
            end
            refill   = ~|(requests & credit_nz);
            eligible = refill ? requests : (requests & credit_nz);
            for (int unsigned k = 0; k < NUM_REQS; k++) begin
                src             = (32'(ptr_q) + k) % 32'(NUM_REQS);
                eligible_rot[k] = eligible[src[LOG_NUM_REQS-1:0]];
            end
        end

        VX_priority_arbiter #(
            .NUM_REQS     (NUM_REQS),
            .LOG_NUM_REQS (LOG_NUM_REQS)
        ) u_prio (
            .requests    (eligible_rot),
            .grant_index (rot_idx)
        );

        // Rotate the picked index back (mod NUM_REQS) and apply the lock override.
        always_comb begin
            int unsigned sum;
            sum = 32'(ptr_q) + 32'(rot_idx);
            if (sum >= 32'(NUM_REQS)) begin
                sum = sum - 32'(NUM_REQS);
            end
            rr_winner = sum[LOG_NUM_REQS-1:0];
            lock_hit  = (lock_st_q == LOCK_ST_LOCKED) && requests[lock_idx_q];
            winner    = lock_hit ? lock_idx_q : rr_winner;
        end

        assign grant_valid = |requests;
        assign accept      = grant_valid & grant_ready;

        // Drive the grant outputs; idle reads as index 0 / no one-hot bit.
        always_comb begin
            grant_index  = grant_valid ? winner : '0;
            grant_onehot = '0;
            if (grant_valid) begin
                grant_onehot[winner] = 1'b1;
            end
        end

        // Next-state: refill/decrement credits, move ptr, update lock FSM.
        always_comb begin
            logic [WEIGHT_WIDTH-1:0] w_eff;
            logic [WEIGHT_WIDTH-1:0] win_credit;
            logic                    lock_next;
            w_eff      = '0;
            win_credit = '0;
            lock_next  = 1'b0;
            credit_d   = credit_q;
            ptr_d      = ptr_q;
            lock_st_d  = lock_st_q;
            lock_idx_d = lock_idx_q;
            if (accept) begin
                if (refill) begin
                    for (int unsigned j = 0; j < NUM_REQS; j++) begin
                        w_eff       = weights[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        credit_d[j] = (w_eff == '0) ? WEIGHT_WIDTH'(1) : w_eff;
                    end
                end
                win_credit = credit_d[winner];
                if (win_credit != '0) begin
                    credit_d[winner] = win_credit - WEIGHT_WIDTH'(1);
                end
                lock_next  = (LOCK_ENABLE != 0) && requests_lock[winner];
                lock_st_d  = lock_next ? LOCK_ST_LOCKED : LOCK_ST_UNLOCKED;
                lock_idx_d = winner;
                if ((credit_d[winner] != '0) && !lock_next) begin
                    ptr_d = winner;
                end else if (winner == LOG_NUM_REQS'(NUM_REQS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = winner + LOG_NUM_REQS'(1);
                end
            end else if ((lock_st_q == LOCK_ST_LOCKED) && !requests[lock_idx_q]) begin
                lock_st_d = LOCK_ST_UNLOCKED;
            end
        end

        // State registers; async reset drops any lock and restarts at index 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ptr_q      <= '0;
                credit_q   <= '0;
                lock_st_q  <= LOCK_ST_UNLOCKED;
                lock_idx_q <= '0;
            end else begin
                ptr_q      <= ptr_d;
                credit_q   <= credit_d;
                lock_st_q  <= lock_st_d;
                lock_idx_q <= lock_idx_d;
            end
        end
    end

endmodule

// File: tb/tb_vx_wrr_arbiter.sv
// Testbench for vx_wrr_arbiter: directed scenarios plus randomized traffic
// against a behavioural credit/pointer model, on 4- and 3-requester instances.
module tb_vx_wrr_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req4, lock4, go4;
    logic [15:0] w4;
    logic        rdy4, gv4;
    logic [1:0]  gi4;

    logic [2:0]  req3, lock3, go3;
    logic [11:0] w3;
    logic        rdy3, gv3;
    logic [1:0]  gi3;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, unit 0 = 4 requesters, unit 1 = 3 requesters.
    int m_cred [2][4];
    int m_ptr  [2];
    bit m_lock [2];
    int m_lidx [2];
    int nreq   [2] = '{4, 3};

    int seq_w [7] = '{0, 1, 1, 2, 2, 2, 3};

    vx_wrr_arbiter #(
        .NUM_REQS     (4),
        .WEIGHT_WIDTH (4),
        .LOCK_ENABLE  (1)
    ) dut4 (
        .clk           (clk),
        .reset_n       (rst_n),
        .requests      (req4),
        .weights       (w4),
        .requests_lock (lock4),
        .grant_index   (gi4),
        .grant_onehot  (go4),
        .grant_valid   (gv4),
        .grant_ready   (rdy4)
    );

    vx_wrr_arbiter #(
        .NUM_REQS     (3),
        .WEIGHT_WIDTH (4),
        .LOCK_ENABLE  (1)
    ) dut3 (
        .clk           (clk),
        .reset_n       (rst_n),
        .requests      (req3),
        .weights       (w3),
        .requests_lock (lock3),
        .grant_index   (gi3),
        .grant_onehot  (go3),
        .grant_valid   (gv3),
        .grant_ready   (rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_winner(input int u, input logic [3:0] req);
        int n;
        bit refill;
        int i;
        n      = nreq[u];
        refill = 1'b1;
        if (m_lock[u] && req[m_lidx[u]]) return m_lidx[u];
        for (int k = 0; k < n; k++)
            if (req[k] && m_cred[u][k] > 0) refill = 1'b0;
        for (int k = 0; k < n; k++) begin
            i = (m_ptr[u] + k) % n;
            if (req[i] && (refill || m_cred[u][i] > 0)) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 4; k++) m_cred[u][k] = 0;
            m_ptr[u]  = 0;
            m_lock[u] = 1'b0;
            m_lidx[u] = 0;
        end
    endtask

    task automatic m_step(input int u, input logic [3:0] req, input logic [3:0] lk,
                          input logic rdy, input logic [15:0] w);
        int  n, win, wv;
        bit  refill;
        n   = nreq[u];
        win = m_winner(u, req);
        if (win >= 0 && rdy) begin
            refill = 1'b1;
            for (int k = 0; k < n; k++)
                if (req[k] && m_cred[u][k] > 0) refill = 1'b0;
            if (refill) begin
                for (int k = 0; k < n; k++) begin
                    wv = int'(w[k*4 +: 4]);
                    m_cred[u][k] = (wv == 0) ? 1 : wv;
                end
            end
            if (m_cred[u][win] > 0) m_cred[u][win]--;
            m_lock[u] = lk[win];
            m_lidx[u] = win;
            m_ptr[u]  = (m_cred[u][win] != 0 && !m_lock[u]) ? win : (win + 1) % n;
        end else if (m_lock[u] && !req[m_lidx[u]]) begin
            m_lock[u] = 1'b0;
        end
    endtask

    task automatic check_now();
        int w;
        w = m_winner(0, req4);
        check_val("u4_valid",  32'(gv4), 32'(|req4));
        check_val("u4_index",  32'(gi4), (w < 0) ? 0 : w);
        check_val("u4_onehot", 32'(go4), (w < 0) ? 0 : (1 << w));
        w = m_winner(1, {1'b0, req3});
        check_val("u3_valid",  32'(gv3), 32'(|req3));
        check_val("u3_index",  32'(gi3), (w < 0) ? 0 : w);
        check_val("u3_onehot", 32'(go3), (w < 0) ? 0 : (1 << w));
    endtask

    // Inputs must be settled; checks, crosses one posedge, advances the model.
    task automatic tick();
        check_now();
        @(posedge clk);
        m_step(0, req4, lock4, rdy4, w4);
        m_step(1, {1'b0, req3}, {1'b0, lock3}, rdy3, {4'h0, w3});
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req4 = '0; lock4 = '0; rdy4 = 1'b0;
        req3 = '0; lock3 = '0; rdy3 = 1'b0;
        m_reset();
        #1;
        check_val("rst_valid4",  32'(gv4), 0);
        check_val("rst_index4",  32'(gi4), 0);
        check_val("rst_onehot4", 32'(go4), 0);
        check_val("rst_valid3",  32'(gv3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int pos;
        rst_n = 1'b0;
        w4 = 16'h0321;
        w3 = 12'h111;
        req4 = '0; lock4 = '0; rdy4 = 1'b0;
        req3 = '0; lock3 = '0; rdy3 = 1'b0;
        #3;
        do_reset();

        // Weighted sequence, three epochs
        w4 = 16'h0321; req4 = 4'hF; rdy4 = 1'b1;
        for (int e = 0; e < 3; e++) begin
            for (int s = 0; s < 7; s++) begin
                #1;
                check_val("wt_seq", 32'(gi4), seq_w[s]);
                tick();
            end
        end

        // Backpressure: ready alternates, sequence only advances on ready
        do_reset();
        req4 = 4'hF;
        pos  = 0;
        for (int c = 0; c < 28; c++) begin
            rdy4 = (c % 2 == 0);
            #1;
            check_val("bp_seq", 32'(gi4), seq_w[pos % 7]);
            tick();
            if (rdy4) pos++;
        end

        // Lock hold, lock end, RR return, lock drop
        do_reset();
        req4 = 4'b0011; lock4 = 4'b0010; rdy4 = 1'b1;
        #1; check_val("lock_first", 32'(gi4), 0); tick();
        for (int b = 0; b < 5; b++) begin
            #1; check_val("lock_hold", 32'(gi4), 1); tick();
        end
        lock4 = 4'b0000;
        #1; check_val("lock_last", 32'(gi4), 1); tick();
        #1; check_val("lock_rr", 32'(gi4), 0); tick();
        lock4 = 4'b0010;
        #1; check_val("lock_reacq", 32'(gi4), 1); tick();
        req4 = 4'b0001; rdy4 = 1'b0;
        #1; check_val("lock_drop", 32'(gi4), 0); tick();

        // Reset while locked
        req4 = 4'b0011; lock4 = 4'b0011; rdy4 = 1'b1;
        #1; tick();
        do_reset();
        req4 = 4'b0011; lock4 = 4'b0000; rdy4 = 1'b1;
        #1; check_val("rst_resume", 32'(gi4), 0); tick();

        // Single requester with weight 1 refills every cycle
        do_reset();
        w4 = 16'h0100; req4 = 4'b0100; rdy4 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            check_val("refill_idx", 32'(gi4), 2);
            check_val("refill_vld", 32'(gv4), 1);
            tick();
        end
        req4 = '0;

        // Three requesters: pointer wraps 2 -> 0
        w3 = 12'h111; req3 = 3'b111; rdy3 = 1'b1;
        for (int b = 0; b < 7; b++) begin
            #1;
            check_val("wrap3_idx", 32'(gi3), b % 3);
            tick();
        end

        // Randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            req4  = 4'($urandom);
            lock4 = 4'($urandom) & 4'($urandom);
            rdy4  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) w4 = 16'($urandom);
            req3  = 3'($urandom);
            lock3 = 3'($urandom) & 3'($urandom);
            rdy3  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) w3 = 12'($urandom);
            #1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
